// File: rtl/plab5_mcore_mem_sec_arbiter_if.sv
// Bus bundle for the security-aware memory arbiter: two requester ports,
// their response ports, and the shared memory request/response port.
interface plab5_mcore_mem_sec_arbiter_if #(
    parameter int p_opaque_nbits = 8,
    parameter int p_addr_nbits   = 32,
    parameter int p_data_nbits   = 32
);
    localparam int req_cnbits  = 3 + p_opaque_nbits + p_addr_nbits + 2;
    localparam int resp_cnbits = 3 + p_opaque_nbits + 2;

    logic [req_cnbits-1:0]   req0_control;
    logic [p_data_nbits-1:0] req0_data;
    logic                    req0_val;
    logic                    req0_rdy;
    logic                    req0_sec_level;

    logic [req_cnbits-1:0]   req1_control;
    logic [p_data_nbits-1:0] req1_data;
    logic                    req1_val;
    logic                    req1_rdy;
    logic                    req1_sec_level;

    logic [resp_cnbits-1:0]  resp0_control;
    logic [p_data_nbits-1:0] resp0_data;
    logic                    resp0_val;
    logic                    resp0_rdy;
    logic                    resp0_sec_level;

    logic [resp_cnbits-1:0]  resp1_control;
    logic [p_data_nbits-1:0] resp1_data;
    logic                    resp1_val;
    logic                    resp1_rdy;
    logic                    resp1_sec_level;

    logic [req_cnbits-1:0]   mem_req_control;
    logic [p_data_nbits-1:0] mem_req_data;
    logic                    mem_req_val;
    logic                    mem_req_rdy;
    logic                    mem_req_sec_level;

    logic [resp_cnbits-1:0]  mem_resp_control;
    logic [p_data_nbits-1:0] mem_resp_data;
    logic                    mem_resp_val;
    logic                    mem_resp_rdy;

    // Arbiter view: answers the requesters, drives the memory request side.
    modport slave (
        input  req0_control, req0_data, req0_val, req0_sec_level,
        output req0_rdy,
        input  req1_control, req1_data, req1_val, req1_sec_level,
        output req1_rdy,
        output resp0_control, resp0_data, resp0_val, resp0_sec_level,
        input  resp0_rdy,
        output resp1_control, resp1_data, resp1_val, resp1_sec_level,
        input  resp1_rdy,
        output mem_req_control, mem_req_data, mem_req_val, mem_req_sec_level,
        input  mem_req_rdy,
        input  mem_resp_control, mem_resp_data, mem_resp_val,
        output mem_resp_rdy
    );

    // Environment view: requesters plus the memory behind the arbiter.
    modport master (
        output req0_control, req0_data, req0_val, req0_sec_level,
        input  req0_rdy,
        output req1_control, req1_data, req1_val, req1_sec_level,
        input  req1_rdy,
        input  resp0_control, resp0_data, resp0_val, resp0_sec_level,
        output resp0_rdy,
        input  resp1_control, resp1_data, resp1_val, resp1_sec_level,
        output resp1_rdy,
        input  mem_req_control, mem_req_data, mem_req_val, mem_req_sec_level,
        output mem_req_rdy,
        output mem_resp_control, mem_resp_data, mem_resp_val,
        input  mem_resp_rdy
    );
endinterface

// File: rtl/plab5_mcore_mem_sec_arbiter.sv
// Round-robin, security-checking arbiter sharing one memory port between two
// requesters; denied requests are answered locally, responses routed by tag FIFO.
module plab5_mcore_mem_sec_arbiter #(
    parameter int p_opaque_nbits    = 8,
    parameter int p_addr_nbits      = 32,
    parameter int p_data_nbits      = 32,
    parameter int p_max_outstanding = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mem_sec_level,
    output logic [7:0] deny_count,
    plab5_mcore_mem_sec_arbiter_if.slave bus
);
    localparam int REQ_CW = 3 + p_opaque_nbits + p_addr_nbits + 2;
    localparam int RESP_CW = 3 + p_opaque_nbits + 2;
    localparam int PTR_W = $clog2(p_max_outstanding);
    localparam logic [PTR_W:0] FIFO_DEPTH = (PTR_W+1)'(p_max_outstanding);

    typedef struct packed {
        logic               deny;
        logic               port;
        logic               sec;
        logic [RESP_CW-1:0] ctrl;
    } tag_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Error response keeps the request's type and opaque, drops the address.
    function automatic logic [RESP_CW-1:0] err_ctrl(input logic [REQ_CW-1:0] c);
        return {c[REQ_CW-1 -: 3 + p_opaque_nbits], c[1:0]};
    endfunction

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             prio;
    logic [7:0]       deny_cnt_r;
    tag_t             tags [p_max_outstanding];

    logic              active;
    logic              fifo_full;
    logic              fifo_empty;
    tag_t              head;
    logic              head_live;
    logic              head_resp_rdy;
    logic              pop;
    logic              space;
    logic              deny0;
    logic              deny1;
    logic              elig0;
    logic              elig1;
    logic              grant0;
    logic              grant1;
    logic              push;
    logic              g_deny;
    logic              g_sec;
    logic [REQ_CW-1:0] g_ctrl;
    logic [p_data_nbits-1:0] g_data;
    logic              fwd;
    tag_t              new_tag;
    logic              sel0;
    logic              sel1;
    logic              resp_val_sel;
    logic [RESP_CW-1:0]      resp_ctrl_sel;
    logic [p_data_nbits-1:0] resp_data_sel;

    // Reset is active-low; every output is forced quiet while it is held.
    assign active     = reset;
    assign fifo_full  = (count == FIFO_DEPTH);
    assign fifo_empty = (count == '0);
    assign head       = tags[rd_ptr];
    assign head_live  = active && !fifo_empty;

    assign head_resp_rdy = head.port ? bus.resp1_rdy : bus.resp0_rdy;
    assign pop = head_live && head_resp_rdy && (head.deny || bus.mem_resp_val);

    // A same-cycle pop frees a slot, so a full FIFO can still take a grant.
    assign space = !fifo_full || pop;

    assign deny0 = !bus.req0_sec_level && mem_sec_level;
    assign deny1 = !bus.req1_sec_level && mem_sec_level;
    assign elig0 = active && bus.req0_val && space && (deny0 || bus.mem_req_rdy);
    assign elig1 = active && bus.req1_val && space && (deny1 || bus.mem_req_rdy);

    assign grant0 = elig0 && (!elig1 || !prio);
    assign grant1 = elig1 && (!elig0 || prio);
    assign push   = grant0 || grant1;

    assign g_deny = grant1 ? deny1 : deny0;
    assign g_sec  = grant1 ? bus.req1_sec_level : bus.req0_sec_level;
    assign g_ctrl = grant1 ? bus.req1_control : bus.req0_control;
    assign g_data = grant1 ? bus.req1_data : bus.req0_data;
    assign fwd    = push && !g_deny;

    assign bus.req0_rdy          = grant0;
    assign bus.req1_rdy          = grant1;
    assign bus.mem_req_val       = fwd;
    assign bus.mem_req_control   = fwd ? g_ctrl : '0;
    assign bus.mem_req_data      = fwd ? g_data : '0;
    assign bus.mem_req_sec_level = fwd && g_sec;

    always_comb begin
        new_tag      = '0;
        new_tag.deny = g_deny;
        new_tag.port = grant1;
        new_tag.sec  = g_deny ? 1'b0 : g_sec;
        new_tag.ctrl = g_deny ? err_ctrl(g_ctrl) : '0;
    end

    // Response side: the head tag picks the port and the response source.
    assign sel0 = head_live && !head.port;
    assign sel1 = head_live && head.port;
    assign resp_val_sel  = head.deny || bus.mem_resp_val;
    assign resp_ctrl_sel = head.deny ? head.ctrl : bus.mem_resp_control;
    assign resp_data_sel = head.deny ? '1 : bus.mem_resp_data;

    assign bus.resp0_val       = sel0 && resp_val_sel;
    assign bus.resp0_control   = sel0 ? resp_ctrl_sel : '0;
    assign bus.resp0_data      = sel0 ? resp_data_sel : '0;
    assign bus.resp0_sec_level = sel0 && head.sec;
    assign bus.resp1_val       = sel1 && resp_val_sel;
    assign bus.resp1_control   = sel1 ? resp_ctrl_sel : '0;
    assign bus.resp1_data      = sel1 ? resp_data_sel : '0;
    assign bus.resp1_sec_level = sel1 && head.sec;
    assign bus.mem_resp_rdy    = head_live && !head.deny && head_resp_rdy;

    assign deny_count = active ? deny_cnt_r : 8'd0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            prio       <= 1'b0;
            deny_cnt_r <= 8'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                prio   <= grant0;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
            if (push && g_deny) begin
                deny_cnt_r <= sat_inc8(deny_cnt_r);
            end
        end
    end

    // Tag storage carries no reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            tags[wr_ptr] <= new_tag;
        end
    end

    a_one_grant: assert property (@(posedge clk) disable iff (!reset)
        !(grant0 && grant1));
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push && fifo_full && !pop));
    a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
        !(pop && fifo_empty));

endmodule

// File: tb/tb_plab5_mcore_mem_sec_arbiter.sv
// Directed bench for plab5_mcore_mem_sec_arbiter with hand-computed expectations.
module tb_plab5_mcore_mem_sec_arbiter;
    logic       clk;
    logic       reset;
    logic       mem_sec_level;
    logic [7:0] deny_count;
    int         vectors;
    int         miscompares;

    plab5_mcore_mem_sec_arbiter_if #(
        .p_opaque_nbits(8), .p_addr_nbits(32), .p_data_nbits(32)
    ) bus ();

    plab5_mcore_mem_sec_arbiter #(
        .p_opaque_nbits(8), .p_addr_nbits(32), .p_data_nbits(32),
        .p_max_outstanding(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mem_sec_level(mem_sec_level),
        .deny_count(deny_count),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [44:0] mk_req(input logic [2:0] t, input logic [7:0] op,
                                           input logic [31:0] a, input logic [1:0] l);
        return {t, op, a, l};
    endfunction

    task automatic idle_inputs();
        mem_sec_level        = 1'b0;
        bus.req0_control     = '0;
        bus.req0_data        = '0;
        bus.req0_val         = 1'b0;
        bus.req0_sec_level   = 1'b0;
        bus.req1_control     = '0;
        bus.req1_data        = '0;
        bus.req1_val         = 1'b0;
        bus.req1_sec_level   = 1'b0;
        bus.resp0_rdy        = 1'b0;
        bus.resp1_rdy        = 1'b0;
        bus.mem_req_rdy      = 1'b0;
        bus.mem_resp_control = '0;
        bus.mem_resp_data    = '0;
        bus.mem_resp_val     = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        mem_sec_level        = 1'b0;
        bus.req0_val         = 1'b1;
        bus.req0_sec_level   = 1'b1;
        bus.req0_control     = mk_req(3'd0, 8'h77, 32'h0000_1234, 2'd0);
        bus.req1_val         = 1'b1;
        bus.mem_req_rdy      = 1'b1;
        bus.mem_resp_val     = 1'b1;
        bus.mem_resp_data    = 32'hCAFE_F00D;
        bus.mem_resp_control = 13'h1FFF;
        bus.resp0_rdy        = 1'b1;
        bus.resp1_rdy        = 1'b1;
        #1;
        vectors++; if (bus.req0_rdy !== 1'b0) begin miscompares++; $display("FAIL rst_req0_rdy got=%0h want=0", bus.req0_rdy); end
        vectors++; if (bus.req1_rdy !== 1'b0) begin miscompares++; $display("FAIL rst_req1_rdy got=%0h want=0", bus.req1_rdy); end
        vectors++; if (bus.mem_req_val !== 1'b0) begin miscompares++; $display("FAIL rst_mem_req_val got=%0h want=0", bus.mem_req_val); end
        vectors++; if (bus.mem_req_control !== 45'd0) begin miscompares++; $display("FAIL rst_mem_req_control got=%0h want=0", bus.mem_req_control); end
        vectors++; if (bus.mem_req_sec_level !== 1'b0) begin miscompares++; $display("FAIL rst_mem_req_sec got=%0h want=0", bus.mem_req_sec_level); end
        vectors++; if (bus.mem_resp_rdy !== 1'b0) begin miscompares++; $display("FAIL rst_mem_resp_rdy got=%0h want=0", bus.mem_resp_rdy); end
        vectors++; if (bus.resp0_val !== 1'b0) begin miscompares++; $display("FAIL rst_resp0_val got=%0h want=0", bus.resp0_val); end
        vectors++; if (bus.resp0_data !== 32'd0) begin miscompares++; $display("FAIL rst_resp0_data got=%0h want=0", bus.resp0_data); end
        vectors++; if (deny_count !== 8'd0) begin miscompares++; $display("FAIL rst_deny_count got=%0d want=0", deny_count); end
        step();
        idle_inputs();
        reset = 1'b1;
        step();
        #1;
        vectors++; if (bus.resp0_val !== 1'b0 || bus.resp1_val !== 1'b0) begin miscompares++; $display("FAIL rst_empty_resp got=%0h%0h want=00", bus.resp0_val, bus.resp1_val); end
    endtask

    task automatic test_same_level();
        logic [44:0] c;
        c = mk_req(3'd0, 8'h05, 32'h0000_1000, 2'd0);
        @(negedge clk);
        mem_sec_level      = 1'b0;
        bus.req0_val       = 1'b1;
        bus.req0_sec_level = 1'b0;
        bus.req0_control   = c;
        bus.req0_data      = 32'h0;
        bus.mem_req_rdy    = 1'b1;
        #1;
        vectors++; if (bus.req0_rdy !== 1'b1) begin miscompares++; $display("FAIL same_req0_rdy got=%0h want=1", bus.req0_rdy); end
        vectors++; if (bus.mem_req_val !== 1'b1) begin miscompares++; $display("FAIL same_mem_req_val got=%0h want=1", bus.mem_req_val); end
        vectors++; if (bus.mem_req_control !== c) begin miscompares++; $display("FAIL same_mem_req_control got=%0h want=%0h", bus.mem_req_control, c); end
        vectors++; if (bus.mem_req_sec_level !== 1'b0) begin miscompares++; $display("FAIL same_mem_req_sec got=%0h want=0", bus.mem_req_sec_level); end
        step();
        bus.req0_val         = 1'b0;
        bus.mem_resp_val     = 1'b1;
        bus.mem_resp_control = 13'h0014;
        bus.mem_resp_data    = 32'hDEAD_BEEF;
        bus.resp0_rdy        = 1'b1;
        bus.resp1_rdy        = 1'b1;
        #1;
        vectors++; if (bus.resp0_val !== 1'b1) begin miscompares++; $display("FAIL same_resp0_val got=%0h want=1", bus.resp0_val); end
        vectors++; if (bus.resp0_control !== 13'h0014) begin miscompares++; $display("FAIL same_resp0_control got=%0h want=14", bus.resp0_control); end
        vectors++; if (bus.resp0_data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL same_resp0_data got=%0h want=deadbeef", bus.resp0_data); end
        vectors++; if (bus.resp1_val !== 1'b0) begin miscompares++; $display("FAIL same_resp1_val got=%0h want=0", bus.resp1_val); end
        vectors++; if (bus.mem_resp_rdy !== 1'b1) begin miscompares++; $display("FAIL same_mem_resp_rdy got=%0h want=1", bus.mem_resp_rdy); end
        step();
        bus.mem_resp_val = 1'b0;
        #1;
        vectors++; if (bus.resp0_val !== 1'b0) begin miscompares++; $display("FAIL same_after_pop got=%0h want=0", bus.resp0_val); end
    endtask

    task automatic test_denial();
        @(negedge clk);
        mem_sec_level      = 1'b1;
        bus.req1_val       = 1'b1;
        bus.req1_sec_level = 1'b0;
        bus.req1_control   = mk_req(3'd1, 8'h22, 32'h0000_2000, 2'd0);
        bus.req1_data      = 32'h0000_1234;
        bus.resp1_rdy      = 1'b1;
        #1;
        vectors++; if (bus.mem_req_val !== 1'b0) begin miscompares++; $display("FAIL deny_mem_req_val got=%0h want=0", bus.mem_req_val); end
        vectors++; if (bus.req1_rdy !== 1'b1) begin miscompares++; $display("FAIL deny_req1_rdy got=%0h want=1", bus.req1_rdy); end
        vectors++; if (bus.resp1_val !== 1'b0) begin miscompares++; $display("FAIL deny_resp1_early got=%0h want=0", bus.resp1_val); end
        step();
        bus.req1_val = 1'b0;
        #1;
        vectors++; if (bus.resp1_val !== 1'b1) begin miscompares++; $display("FAIL deny_resp1_val got=%0h want=1", bus.resp1_val); end
        vectors++; if (bus.resp1_control !== 13'h0488) begin miscompares++; $display("FAIL deny_resp1_control got=%0h want=488", bus.resp1_control); end
        vectors++; if (bus.resp1_data !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL deny_resp1_data got=%0h want=ffffffff", bus.resp1_data); end
        vectors++; if (bus.resp0_val !== 1'b0) begin miscompares++; $display("FAIL deny_resp0_val got=%0h want=0", bus.resp0_val); end
        vectors++; if (bus.mem_resp_rdy !== 1'b0) begin miscompares++; $display("FAIL deny_mem_resp_rdy got=%0h want=0", bus.mem_resp_rdy); end
        vectors++; if (deny_count !== 8'd1) begin miscompares++; $display("FAIL deny_count got=%0d want=1", deny_count); end
        step();
    endtask

    task automatic test_fairness();
        logic [44:0] ca;
        logic [44:0] cb;
        do_reset();
        ca = mk_req(3'd0, 8'h10, 32'h0000_0100, 2'd0);
        cb = mk_req(3'd0, 8'h11, 32'h0000_0200, 2'd0);
        bus.req0_val     = 1'b1;
        bus.req0_control = ca;
        bus.req1_val     = 1'b1;
        bus.req1_control = cb;
        bus.mem_req_rdy  = 1'b1;
        bus.mem_resp_val = 1'b1;
        bus.resp0_rdy    = 1'b1;
        bus.resp1_rdy    = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            vectors++; if (bus.req0_rdy !== (i % 2 == 0)) begin miscompares++; $display("FAIL fair_req0_rdy[%0d] got=%0h want=%0h", i, bus.req0_rdy, (i % 2 == 0)); end
            vectors++; if (bus.req1_rdy !== (i % 2 == 1)) begin miscompares++; $display("FAIL fair_req1_rdy[%0d] got=%0h want=%0h", i, bus.req1_rdy, (i % 2 == 1)); end
            vectors++; if (bus.mem_req_control !== ((i % 2 == 0) ? ca : cb)) begin miscompares++; $display("FAIL fair_ctrl[%0d] got=%0h want=%0h", i, bus.mem_req_control, ((i % 2 == 0) ? ca : cb)); end
            step();
        end
    endtask

    task automatic test_ordering();
        do_reset();
        mem_sec_level      = 1'b1;
        bus.req0_val       = 1'b1;
        bus.req0_sec_level = 1'b1;
        bus.req0_control   = mk_req(3'd0, 8'h31, 32'h0000_3000, 2'd0);
        bus.mem_req_rdy    = 1'b1;
        bus.resp0_rdy      = 1'b1;
        bus.resp1_rdy      = 1'b1;
        #1;
        vectors++; if (bus.req0_rdy !== 1'b1 || bus.mem_req_val !== 1'b1) begin miscompares++; $display("FAIL ord_grant0 got=%0h%0h want=11", bus.req0_rdy, bus.mem_req_val); end
        vectors++; if (bus.mem_req_sec_level !== 1'b1) begin miscompares++; $display("FAIL ord_mem_req_sec got=%0h want=1", bus.mem_req_sec_level); end
        step();
        bus.req0_val       = 1'b0;
        bus.req1_val       = 1'b1;
        bus.req1_sec_level = 1'b0;
        bus.req1_control   = mk_req(3'd1, 8'h42, 32'h0000_4000, 2'd0);
        #1;
        vectors++; if (bus.req1_rdy !== 1'b1 || bus.mem_req_val !== 1'b0) begin miscompares++; $display("FAIL ord_deny1 got=%0h%0h want=10", bus.req1_rdy, bus.mem_req_val); end
        step();
        bus.req1_val = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            vectors++; if (bus.resp1_val !== 1'b0 || bus.resp0_val !== 1'b0) begin miscompares++; $display("FAIL ord_wait[%0d] got=%0h%0h want=00", k, bus.resp0_val, bus.resp1_val); end
            step();
        end
        bus.mem_resp_val     = 1'b1;
        bus.mem_resp_control = 13'h00C4;
        bus.mem_resp_data    = 32'h0000_A5A5;
        #1;
        vectors++; if (bus.resp0_val !== 1'b1 || bus.resp1_val !== 1'b0) begin miscompares++; $display("FAIL ord_resp0_first got=%0h%0h want=10", bus.resp0_val, bus.resp1_val); end
        vectors++; if (bus.resp0_control !== 13'h00C4) begin miscompares++; $display("FAIL ord_resp0_control got=%0h want=c4", bus.resp0_control); end
        vectors++; if (bus.resp0_sec_level !== 1'b1) begin miscompares++; $display("FAIL ord_resp0_sec got=%0h want=1", bus.resp0_sec_level); end
        step();
        bus.mem_resp_val = 1'b0;
        #1;
        vectors++; if (bus.resp1_val !== 1'b1 || bus.resp0_val !== 1'b0) begin miscompares++; $display("FAIL ord_resp1_second got=%0h%0h want=01", bus.resp0_val, bus.resp1_val); end
        vectors++; if (bus.resp1_control !== 13'h0508) begin miscompares++; $display("FAIL ord_resp1_control got=%0h want=508", bus.resp1_control); end
        vectors++; if (bus.resp1_sec_level !== 1'b0) begin miscompares++; $display("FAIL ord_resp1_sec got=%0h want=0", bus.resp1_sec_level); end
        step();
        #1;
        vectors++; if (bus.resp1_val !== 1'b0) begin miscompares++; $display("FAIL ord_drained got=%0h want=0", bus.resp1_val); end
    endtask

    task automatic test_full();
        do_reset();
        bus.req0_val     = 1'b1;
        bus.req0_control = mk_req(3'd0, 8'h50, 32'h0000_5000, 2'd0);
        bus.mem_req_rdy  = 1'b1;
        bus.resp0_rdy    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++; if (bus.req0_rdy !== 1'b1) begin miscompares++; $display("FAIL full_fill[%0d] got=%0h want=1", i, bus.req0_rdy); end
            step();
        end
        #1;
        vectors++; if (bus.req0_rdy !== 1'b0 || bus.mem_req_val !== 1'b0) begin miscompares++; $display("FAIL full_block got=%0h%0h want=00", bus.req0_rdy, bus.mem_req_val); end
        bus.mem_resp_val     = 1'b1;
        bus.mem_resp_control = 13'h0140;
        #1;
        vectors++; if (bus.req0_rdy !== 1'b1) begin miscompares++; $display("FAIL full_pop_grant got=%0h want=1", bus.req0_rdy); end
        vectors++; if (bus.mem_resp_rdy !== 1'b1 || bus.resp0_val !== 1'b1) begin miscompares++; $display("FAIL full_pop_resp got=%0h%0h want=11", bus.mem_resp_rdy, bus.resp0_val); end
        step();
        bus.mem_resp_val = 1'b0;
        #1;
        vectors++; if (bus.req0_rdy !== 1'b0) begin miscompares++; $display("FAIL full_still_full got=%0h want=0", bus.req0_rdy); end
    endtask

    task automatic test_saturation_reset();
        do_reset();
        mem_sec_level      = 1'b1;
        bus.req0_val       = 1'b1;
        bus.req1_val       = 1'b1;
        bus.req1_control   = mk_req(3'd1, 8'h66, 32'h0000_6000, 2'd0);
        bus.resp0_rdy      = 1'b1;
        bus.resp1_rdy      = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (i == 200) begin
                #1;
                vectors++; if (deny_count !== 8'd200) begin miscompares++; $display("FAIL sat_mid got=%0d want=200", deny_count); end
            end
            step();
        end
        #1;
        vectors++; if (deny_count !== 8'd255) begin miscompares++; $display("FAIL sat_final got=%0d want=255", deny_count); end
        reset = 1'b0;
        #1;
        vectors++; if (bus.req0_rdy !== 1'b0 || bus.req1_rdy !== 1'b0) begin miscompares++; $display("FAIL sat_rst_rdy got=%0h%0h want=00", bus.req0_rdy, bus.req1_rdy); end
        vectors++; if (bus.resp0_val !== 1'b0 || bus.resp1_val !== 1'b0) begin miscompares++; $display("FAIL sat_rst_val got=%0h%0h want=00", bus.resp0_val, bus.resp1_val); end
        vectors++; if (bus.resp1_data !== 32'd0 || bus.resp1_control !== 13'd0) begin miscompares++; $display("FAIL sat_rst_resp1 got=%0h/%0h want=0/0", bus.resp1_data, bus.resp1_control); end
        vectors++; if (deny_count !== 8'd0) begin miscompares++; $display("FAIL sat_rst_count got=%0d want=0", deny_count); end
        step();
        idle_inputs();
        reset = 1'b1;
        #1;
        vectors++; if (deny_count !== 8'd0) begin miscompares++; $display("FAIL sat_cleared got=%0d want=0", deny_count); end
        vectors++; if (bus.resp1_val !== 1'b0 || bus.mem_resp_rdy !== 1'b0) begin miscompares++; $display("FAIL sat_fifo_cleared got=%0h%0h want=00", bus.resp1_val, bus.mem_resp_rdy); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        test_reset();
        test_same_level();
        test_denial();
        test_fairness();
        test_ordering();
        test_full();
        test_saturation_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
